// File: rtl/modmul_ctrl.sv
// Iterative (A*B) mod M by MSB-first shift-add with two conditional subtractions per bit,
// all on one shared (n+2)-bit carry adder. Optional operand range check: MODMUL_CHECK_EN.
module modmul_ctrl #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [n-1:0] M,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] R,
  output logic         err
);

  localparam int AW = n + 2;
  localparam int IW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT_ADD, RED1, RED2} state_t;

  state_t          state;
  logic [n-1:0]    a_reg, b_reg, m_reg;
  logic [AW-1:0]   acc;
  logic [IW-1:0]   i;

  logic [AW-1:0]   add_x, add_y;
  logic            add_cin;
  logic [AW:0]     sum;

  // The adder either accumulates 2*acc + partial product, or forms acc - M where
  // the carry-out doubles as the acc >= M decision.
  always_comb begin
    add_x   = acc;
    add_y   = ~{2'b00, m_reg};
    add_cin = 1'b1;
    if (state == SHIFT_ADD) begin
      add_x   = {acc[AW-2:0], 1'b0};
      add_y   = b_reg[i] ? {2'b00, a_reg} : '0;
      add_cin = 1'b0;
    end
    sum = {1'b0, add_x} + {1'b0, add_y} + {{AW{1'b0}}, add_cin};
  end

`ifdef MODMUL_CHECK_EN
  logic bad_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      m_reg <= '0;
      acc   <= '0;
      i     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      R     <= '0;
`ifdef MODMUL_CHECK_EN
      err     <= 1'b0;
      bad_reg <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            m_reg <= M;
            acc   <= '0;
            i     <= IW'(n - 1);
            busy  <= 1'b1;
            state <= SHIFT_ADD;
`ifdef MODMUL_CHECK_EN
            bad_reg <= (M == '0) || (A >= M) || (B >= M);
            err     <= 1'b0;
`endif
          end
        end
        SHIFT_ADD: begin
`ifdef MODMUL_CHECK_EN
          if (bad_reg) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
            R     <= '0;
          end else begin
            acc   <= sum[AW-1:0];
            state <= RED1;
          end
`else
          acc   <= sum[AW-1:0];
          state <= RED1;
`endif
        end
        RED1: begin
          if (sum[AW]) acc <= sum[AW-1:0];
          state <= RED2;
        end
        RED2: begin
          if (i == '0) begin
            R     <= sum[AW] ? sum[n-1:0] : acc[n-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            i     <= i - 1'b1;
            state <= SHIFT_ADD;
          end
          if (sum[AW]) acc <= sum[AW-1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MODMUL_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_modmul_ctrl.sv
// Self-checking bench for modmul_ctrl: directed cases, exhaustive sweeps and random
// operands compared against (A*B) mod M.
module tb_modmul_ctrl;

  localparam int n = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [n-1:0] A, B, M;
  logic         busy, done, err;
  logic [n-1:0] R;

  int n_total = 0;
  int n_pass  = 0;

  modmul_ctrl #(.n(n)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .M(M),
    .busy(busy), .done(done), .R(R), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
  endtask

  function automatic int ref_mod(input int a, input int b, input int m);
    return (a * b) % m;
  endfunction

  // Present operands with start for one edge (edge 0); returns #1 after that edge.
  task automatic start_op(input int a, input int b, input int m);
    A = n'(a); B = n'(b); M = n'(m); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done; mid>0 injects a start with other operands at that cycle.
  task automatic wait_done(input int a, input int b, input int m, input int mid);
    int  cnt = 0;
    bit  busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (mid != 0 && k == mid) begin
        start = 1'b1; A = 4'd3; B = 4'd4; M = 4'd11;
      end
      if (mid != 0 && k == mid + 1) start = 1'b0;
      if (done) begin
        cnt = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    $display("op A=%0d B=%0d M=%0d -> R=%0d err=%0d latency=%0d", a, b, m, R, err, cnt);
    check("latency", cnt, 3 * n);
    check("result", int'(R), ref_mod(a, b, m));
    check("err_clear", int'(err), 0);
    check("busy_low_at_done", int'(busy), 0);
    check("busy_during_op", int'(busy_ok), 1);
  endtask

  task automatic run_op(input int a, input int b, input int m);
    start_op(a, b, m);
    check("busy_after_start", int'(busy), 1);
    wait_done(a, b, m, 0);
  endtask

  initial begin
    int  ms[4];
    logic [n-1:0] r_hold;
    bit  stable;
    int  rm, ra, rb;

    ms = '{1, 7, 13, 15};
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; M = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err",  int'(err), 0);
    check("reset_R",    int'(R), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(7, 9, 13);
    run_op(12, 12, 13);
    run_op(0, 9, 13);
    run_op(0, 0, 1);

    // Start during the operation is ignored.
    start_op(7, 9, 13);
    wait_done(7, 9, 13, 5);

    // Start in the done cycle is accepted with no bubble.
    start_op(12, 11, 13);
    wait_done(12, 11, 13, 0);
    start_op(5, 6, 7);
    check("b2b_busy", int'(busy), 1);
    wait_done(5, 6, 7, 0);

    // R stability with wandering inputs and no start.
    r_hold = R;
    stable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      A = n'($urandom); B = n'($urandom); M = n'($urandom);
      @(posedge clk); #1;
      if (done || R !== r_hold || busy) stable = 1'b0;
    end
    check("r_stable", int'(stable), 1);

    // Asynchronous reset mid-operation.
    start_op(7, 9, 13);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", int'(busy), 0);
    check("mid_reset_done", int'(done), 0);
    check("mid_reset_err",  int'(err), 0);
    check("mid_reset_R",    int'(R), 0);
    #20 rst_n = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done || busy) stable = 1'b0;
    end
    check("no_done_after_reset", int'(stable), 1);
    run_op(7, 9, 13);

`ifdef MODMUL_CHECK_EN
    start_op(13, 2, 13);
    @(posedge clk); #1;
    $display("op A=13 B=2 M=13 (range error) -> R=%0d err=%0d done=%0d", R, err, done);
    check("chk_done", int'(done), 1);
    check("chk_err",  int'(err), 1);
    check("chk_R",    int'(R), 0);
    check("chk_busy", int'(busy), 0);
    @(posedge clk); #1;
    check("chk_done_pulse", int'(done), 0);
    check("chk_err_hold", int'(err), 1);
    run_op(3, 4, 13);
`endif

    foreach (ms[mi]) begin
      for (int a = 0; a < ms[mi]; a++)
        for (int b = 0; b < ms[mi]; b++)
          run_op(a, b, ms[mi]);
    end

    for (int k = 0; k < 40; k++) begin
      rm = int'($urandom_range(15, 1));
      ra = int'($urandom_range(rm - 1, 0));
      rb = int'($urandom_range(rm - 1, 0));
      run_op(ra, rb, rm);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
